// File: rtl/bio_pkg.sv
// Shared constants and helpers for the board I/O input-conditioning path.
// Also consumed by the I/O register block for its port widths.
package bio_pkg;

    localparam int BIO_NUM_KEYS  = 3;
    localparam int BIO_NUM_SW    = 18;
    localparam int BIO_TICK_DIV  = 50000;
    localparam int BIO_DEB_TICKS = 10;

    function automatic int bio_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int bio_max1(input int value);
        return (value < 1) ? 1 : value;
    endfunction

endpackage

// File: rtl/bio_debounce_cell.sv
// One-bit two-flop synchronizer followed by a tick-paced debounce counter.
// rise pulses in the cycle before dout goes 0->1, aligned to that edge.
module debounce_cell
    import bio_pkg::*;
#(
    parameter int DEB_TICKS = BIO_DEB_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic din,
    output logic dout,
    output logic rise
);

    localparam int CW = bio_max1(bio_clog2(DEB_TICKS + 1));
    localparam logic [CW-1:0] LAST = CW'(DEB_TICKS - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_done;

    assign w_diff = r_s2 ^ r_stable;
    assign w_done = w_diff & tick & (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_s1 <= din;
            r_s2 <= r_s1;
            // any return to the accepted level restarts the count
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else if (tick) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign dout = r_stable;
    assign rise = w_done & r_s2;

endmodule

// File: rtl/bio_debounce.sv
// Debounces active-low keys and slide switches on a shared tick prescaler,
// and keeps sticky per-key press flags with masked clear.
module bio_debounce
    import bio_pkg::*;
#(
    parameter int NUM_KEYS  = BIO_NUM_KEYS,
    parameter int NUM_SW    = BIO_NUM_SW,
    parameter int TICK_DIV  = BIO_TICK_DIV,
    parameter int DEB_TICKS = BIO_DEB_TICKS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_n_in,
    input  logic [NUM_SW-1:0]   sw_in,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_SW-1:0]   sw_stable,
    output logic [NUM_KEYS-1:0] key_event,
    input  logic                ev_clr,
    input  logic [NUM_KEYS-1:0] ev_clr_mask
);

    localparam int PW = bio_max1(bio_clog2(TICK_DIV));
    localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]       r_pcnt;
    logic                w_tick;
    logic [NUM_KEYS-1:0] r_event;
    logic [NUM_KEYS-1:0] w_key_rise;
    logic [NUM_KEYS-1:0] w_clr;
    logic [NUM_SW-1:0]   w_unused_sw_rise;

    assign w_tick = (r_pcnt == PLAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt <= '0;
        end else if (w_tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

    // keys are inverted up front so every cell sees 1 = active
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        debounce_cell #(
            .DEB_TICKS(DEB_TICKS)
        ) u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .tick (w_tick),
            .din  (~key_n_in[g]),
            .dout (key_down[g]),
            .rise (w_key_rise[g])
        );
    end

    for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
        debounce_cell #(
            .DEB_TICKS(DEB_TICKS)
        ) u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .tick (w_tick),
            .din  (sw_in[g]),
            .dout (sw_stable[g]),
            .rise (w_unused_sw_rise[g])
        );
    end

    assign w_clr = {NUM_KEYS{ev_clr}} & ev_clr_mask;

    // a press landing on the clear edge keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_event <= '0;
        end else begin
            r_event <= (r_event & ~w_clr) | w_key_rise;
        end
    end

    assign key_event = r_event;

endmodule

// File: tb/tb_bio_debounce.sv
// Directed and randomized checks of bio_debounce against a window model.
// A second instance exercises the prescaled tick path.
module tb_bio_debounce;

    localparam int NK  = 3;
    localparam int NS  = 18;
    localparam int NB  = NK + NS;
    localparam int DEB = 4;

    logic          clk;
    logic          rst_n;
    logic [NK-1:0] key_n_a;
    logic [NS-1:0] sw_a;
    logic [NK-1:0] key_down_a;
    logic [NS-1:0] sw_stable_a;
    logic [NK-1:0] key_event_a;
    logic          ev_clr_a;
    logic [NK-1:0] ev_mask_a;

    logic [NK-1:0] key_n_b;
    logic [NS-1:0] sw_b;
    logic [NK-1:0] key_down_b;
    logic [NS-1:0] sw_stable_b;
    logic [NK-1:0] key_event_b;

    int n_cmp;
    int n_err;

    logic [NB-1:0] hist [0:DEB];
    logic [NB-1:0] m_stable;
    logic [NK-1:0] m_event;

    bio_debounce #(
        .NUM_KEYS (NK),
        .NUM_SW   (NS),
        .TICK_DIV (1),
        .DEB_TICKS(DEB)
    ) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_n_in   (key_n_a),
        .sw_in      (sw_a),
        .key_down   (key_down_a),
        .sw_stable  (sw_stable_a),
        .key_event  (key_event_a),
        .ev_clr     (ev_clr_a),
        .ev_clr_mask(ev_mask_a)
    );

    bio_debounce #(
        .NUM_KEYS (NK),
        .NUM_SW   (NS),
        .TICK_DIV (4),
        .DEB_TICKS(DEB)
    ) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_n_in   (key_n_b),
        .sw_in      (sw_b),
        .key_down   (key_down_b),
        .sw_stable  (sw_stable_b),
        .key_event  (key_event_b),
        .ev_clr     (1'b0),
        .ev_clr_mask(3'b000)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k <= DEB; k++) hist[k] = '0;
        m_stable = '0;
        m_event  = '0;
    endtask

    // A level is accepted once the synchronized value has disagreed with
    // it on each of the last DEB edges (every edge is a tick here).
    task automatic model_edge();
        logic [NB-1:0] raw;
        logic [NB-1:0] nxt;
        logic          allm;
        raw = {sw_a, ~key_n_a};
        nxt = m_stable;
        for (int b = 0; b < NB; b++) begin
            allm = 1'b1;
            for (int k = 1; k <= DEB; k++) begin
                if (hist[k][b] == m_stable[b]) allm = 1'b0;
            end
            if (allm) nxt[b] = ~m_stable[b];
        end
        m_event = (m_event & ~(ev_clr_a ? ev_mask_a : 3'b000))
                | (nxt[NK-1:0] & ~m_stable[NK-1:0]);
        for (int k = DEB; k > 0; k--) hist[k] = hist[k-1];
        hist[0]  = raw;
        m_stable = nxt;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_key_down", 32'(key_down_a), 32'(m_stable[NK-1:0]));
        chk("model_sw_stable", 32'(sw_stable_a), 32'(m_stable[NB-1:NK]));
        chk("model_key_event", 32'(key_event_a), 32'(m_event));
    endtask

    initial begin
        int hold;
        int first;
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        key_n_a   = 3'b111;
        sw_a      = '0;
        ev_clr_a  = 1'b0;
        ev_mask_a = '0;
        key_n_b   = 3'b111;
        sw_b      = '0;
        model_reset();

        // reset and idle
        #23;
        chk("rst_key_down", 32'(key_down_a), 32'd0);
        chk("rst_sw_stable", 32'(sw_stable_a), 32'd0);
        chk("rst_key_event", 32'(key_event_a), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("idle_b", 32'({key_down_b, sw_stable_b, key_event_b}),
                32'd0);
        end

        // clean press and release of key0
        key_n_a = 3'b110;
        for (int k = 1; k <= 18; k++) begin
            step();
            chk("press_down", 32'(key_down_a[0]),
                32'((k >= 6) && (k < 16)));
            chk("press_event", 32'(key_event_a[0]), 32'(k >= 6));
            if (k == 10) key_n_a = 3'b111;
        end

        // 3-cycle glitch on key1 must be rejected
        key_n_a = 3'b101;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("glitch_down", 32'(key_down_a[1]), 32'd0);
            chk("glitch_event", 32'(key_event_a[1]), 32'd0);
            if (k == 3) key_n_a = 3'b111;
        end

        // 4-cycle low on key1 is accepted at edge 6
        key_n_a = 3'b101;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k == 5) chk("hold4_pre", 32'(key_down_a[1]), 32'd0);
            if (k == 6) chk("hold4_rise", 32'(key_down_a[1]), 32'd1);
            if (k == 4) key_n_a = 3'b111;
        end

        // clear colliding with a fresh key0 press, then a plain clear
        key_n_a = 3'b110;
        for (int k = 1; k <= 5; k++) step();
        ev_clr_a  = 1'b1;
        ev_mask_a = 3'b001;
        step();
        chk("clr_collide", 32'(key_event_a[0]), 32'd1);
        step();
        chk("clr_next", 32'(key_event_a[0]), 32'd0);
        chk("clr_others", 32'(key_event_a[2:1]), 32'b01);
        ev_clr_a  = 1'b0;
        ev_mask_a = '0;
        key_n_a   = 3'b111;
        for (int k = 0; k < 10; k++) step();

        // randomized stream
        hold = 0;
        for (int c = 0; c < 400; c++) begin
            if (hold == 0) begin
                hold = $urandom_range(1, 7);
                if ($urandom_range(0, 1) == 1) key_n_a = 3'($urandom);
                if ($urandom_range(0, 2) == 0)
                    sw_a = sw_a ^ (18'd1 << $urandom_range(0, 17));
            end
            hold--;
            ev_clr_a  = ($urandom_range(0, 7) == 0);
            ev_mask_a = 3'($urandom);
            step();
        end
        ev_clr_a = 1'b0;
        key_n_a  = 3'b111;
        sw_a     = '0;
        for (int k = 0; k < 12; k++) step();

        // reset in the middle of a key2 debounce
        key_n_a = 3'b011;
        for (int k = 1; k <= 4; k++) step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_down", 32'(key_down_a), 32'd0);
        chk("midrst_sw", 32'(sw_stable_a), 32'd0);
        chk("midrst_event", 32'(key_event_a), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("postrst_down2", 32'(key_down_a[2]), 32'(k >= 6));
        end
        key_n_a = 3'b111;
        for (int k = 0; k < 10; k++) step();

        // prescaled switch at a random prescaler phase
        hold = $urandom_range(0, 7);
        for (int k = 0; k < hold; k++) step();
        sw_b[17] = 1'b1;
        first = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (first == 0 && sw_stable_b[17]) first = k;
        end
        chk("presc_window", 32'((first >= 15) && (first <= 18)), 32'd1);
        chk("presc_others", 32'(sw_stable_b[16:0]), 32'd0);
        chk("presc_keys", 32'({key_down_b, key_event_b}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
